data_mem_port: RTL and testbench
================================

# data_mem_port

Load/store front end sitting between the MEM pipeline stage and the data-memory bus. It turns a stage-level `MemRead`/`MemWrite` request into a valid/ready bus transaction and holds the pipeline with `stall` until the response returns. For stores it produces the byte strobes; for loads it extracts and sign- or zero-extends the bytes into `readData_M`, which the write-back selector consumes.

## Interface

Parameters:
- `ADDR_W`, 64: byte-address width.
- `DATA_W`, 64: bus data width. Fixed at 64 (8 byte lanes).

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request from the MEM stage.
- `MemWrite`  in  1  store request. `MemRead` and `MemWrite` are never both 1.
- `funct3`  in  3  access size and sign (RV64 encoding).
- `addr`  in  64  effective byte address (the ALU result).
- `storeData`  in  64  rs2 value; the low bytes are used.
- `readData_M`  out  64  extended load result.
- `stall`  out  1  holds the pipeline while an access is pending.
- `fault`  out  1  one-cycle pulse on a misaligned or illegal access.
- `req_valid`  out  1  bus request valid.
- `req_ready`  in  1  bus accepts the request.
- `req_write`  out  1  1 = store, 0 = load.
- `req_addr`  out  64  `{addr[63:3], 3'b000}`.
- `req_wdata`  out  64  store data shifted to its byte lanes.
- `req_wstrb`  out  8  byte-lane enables; 0 for loads.
- `resp_valid`  in  1  response or write-acknowledge, one cycle.
- `resp_rdata`  in  64  aligned 64-bit read data.

## Operation

- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**
  - On `MemRead|MemWrite` with a legal, aligned access: latch `funct3`, `addr[2:0]` and the write flag; register the `req_*` outputs; go to REQ.
  - On an illegal or misaligned access: pulse `fault`, issue no request, stay in IDLE.
- **REQ:** `req_valid` = 1, with `req_*` held stable. When `req_ready` is 1, go to RESP and drop `req_valid` on the next cycle.
- **RESP:** wait for `resp_valid`.
  - On a load, register the extracted result into `readData_M`.
  - Go to DONE for both loads and stores.
- **DONE:** the pipeline advances this cycle. Requests are ignored in this state. Go to IDLE.
- **Legality rules**
  - `funct3 = 111` is illegal for loads.
  - `funct3[2] = 1` is illegal for stores.
  - Alignment is required: halfword needs `addr[0] = 0`, word needs `addr[1:0] = 0`, doubleword needs `addr[2:0] = 0`.
- **Store lanes:** `req_wstrb` = (`0x01`/`0x03`/`0x0F`/`0xFF` by size) << `addr[2:0]`; `req_wdata` = `storeData << (8*addr[2:0])`.
- **Load extract:** `sh` = `resp_rdata >> (8*off)`. Then:
  - LB: sign-extend `sh[7:0]`; LH: sign-extend `sh[15:0]`; LW: sign-extend `sh[31:0]`; LD: `sh`.
  - LBU, LHU, LWU: zero-extend the same fields.
- `readData_M` holds its value until the next load completes; stores and faults leave it unchanged.

## Timing

- **Reset values:** state IDLE; `readData_M`, `req_addr`, `req_wdata` = 0; `req_wstrb` = 0; `req_valid`, `req_write`, `fault` = 0.
- **`stall`** is combinational: (IDLE & legal request) | REQ | RESP. It is 0 in DONE and for faulting accesses.
- **Minimum latency:** `req_ready` = 1 on the first REQ cycle and `resp_valid` on the cycle after gives request cycle T, REQ at T+1, RESP at T+2, DONE at T+3. `readData_M` is valid from T+3; stall is high for T..T+2.
- **Response timing:** a `resp_valid` arriving in the same cycle that REQ sees `req_ready` is not legal bus behaviour. The response comes at the earliest one cycle after acceptance.
- **Stray response:** a `resp_valid` seen in IDLE, REQ or DONE is ignored.
- **`fault`** is registered: it asserts the cycle after the faulting request is seen and lasts one cycle.
- **Reset mid-transaction:** asynchronously returns to IDLE and drops `req_valid` immediately. The bus side must tolerate an abandoned request.
- At most one outstanding transaction; no pipelining.

## Test plan

- **LB, sign-extending:** `addr = 0x1003`, `resp_rdata = 0x0000_0000_80FF_0000` (byte 3 = `0x80`), `req_ready` tied 1, response one cycle after acceptance -> `req_addr = 0x1000`, `stall` high for 3 cycles, `readData_M = 0xFFFF_FFFF_FFFF_FF80`.
- **LWU upper word:** `addr = 0x2004`, `resp_rdata = 0x8765_4321_0000_0000` -> `readData_M = 0x0000_0000_8765_4321`.
- **SH to offset 6:** `storeData = 0xBEEF` -> `req_write = 1`, `req_wstrb = 0xC0`, `req_wdata[63:48] = 0xBEEF`; `readData_M` unchanged.
- **Back-pressure:** `req_ready` low for 4 cycles -> `req_valid` and `req_*` stable throughout, `stall` high; then one transfer only.
- **Misaligned LW:** `addr = 0x3002` -> no `req_valid`, `fault` pulses 1 cycle, `stall` stays 0. `funct3 = 111` load -> same response.
- **Reset during RESP:** `rst_n` low -> state IDLE, `readData_M = 0`, `stall = 0`; the late `resp_valid` is ignored.

Source files
------------

// File: rtl/data_mem_port.sv
// Load/store front end between the MEM stage and the data-memory bus.
// Issues one valid/ready transaction at a time, stalls the pipeline, and aligns/extends load data.
module data_mem_port #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     storeData,
  output logic [DATA_W-1:0]     readData_M,
  output logic                  stall,
  output logic                  fault,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W/8-1:0]   req_wstrb,
  input  logic                  resp_valid,
  input  logic [DATA_W-1:0]     resp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} stateT;

  stateT               state, stateD;
  logic [2:0]          fn3Q, fn3D;
  logic [2:0]          offQ, offD;
  logic                reqValidD, reqWriteD, faultD;
  logic [ADDR_W-1:0]   reqAddrD;
  logic [DATA_W-1:0]   reqWdataD, readDataD;
  logic [DATA_W/8-1:0] reqWstrbD;

  logic                isReq, misaligned, fnOk, legal;
  logic [DATA_W/8-1:0] strbBase;
  logic [DATA_W-1:0]   sh, loadExt;

  // Request legality: size/sign encoding plus natural alignment.
  always_comb begin
    isReq = MemRead | MemWrite;
    misaligned = 1'b0;
    strbBase = 8'h01;
    case (funct3[1:0])
      2'd0: begin misaligned = 1'b0;        strbBase = 8'h01; end
      2'd1: begin misaligned = addr[0];     strbBase = 8'h03; end
      2'd2: begin misaligned = |addr[1:0];  strbBase = 8'h0F; end
      default: begin misaligned = |addr[2:0]; strbBase = 8'hFF; end
    endcase
    fnOk  = MemWrite ? ~funct3[2] : (funct3 != 3'b111);
    legal = fnOk & ~misaligned;
  end

  // Byte-lane extraction and extension of the returned doubleword.
  always_comb begin
    sh = resp_rdata >> {offQ, 3'b000};
    case (fn3Q)
      3'b000:  loadExt = {{56{sh[7]}},  sh[7:0]};
      3'b001:  loadExt = {{48{sh[15]}}, sh[15:0]};
      3'b010:  loadExt = {{32{sh[31]}}, sh[31:0]};
      3'b100:  loadExt = {56'd0, sh[7:0]};
      3'b101:  loadExt = {48'd0, sh[15:0]};
      3'b110:  loadExt = {32'd0, sh[31:0]};
      default: loadExt = sh;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    stateD    = state;
    fn3D      = fn3Q;
    offD      = offQ;
    reqValidD = req_valid;
    reqWriteD = req_write;
    reqAddrD  = req_addr;
    reqWdataD = req_wdata;
    reqWstrbD = req_wstrb;
    readDataD = readData_M;
    faultD    = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (isReq) begin
          if (legal) begin
            stall     = 1'b1;
            stateD    = REQ;
            fn3D      = funct3;
            offD      = addr[2:0];
            reqValidD = 1'b1;
            reqWriteD = MemWrite;
            reqAddrD  = {addr[ADDR_W-1:3], 3'b000};
            reqWdataD = MemWrite ? (storeData << {addr[2:0], 3'b000}) : '0;
            reqWstrbD = MemWrite ? (strbBase << addr[2:0]) : '0;
          end else begin
            faultD = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (req_ready) begin
          stateD    = RESP;
          reqValidD = 1'b0;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (resp_valid) begin
          stateD = DONE;
          if (!req_write) readDataD = loadExt;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fn3Q       <= 3'd0;
      offQ       <= 3'd0;
      req_valid  <= 1'b0;
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      readData_M <= '0;
      fault      <= 1'b0;
    end else begin
      state      <= stateD;
      fn3Q       <= fn3D;
      offQ       <= offD;
      req_valid  <= reqValidD;
      req_write  <= reqWriteD;
      req_addr   <= reqAddrD;
      req_wdata  <= reqWdataD;
      req_wstrb  <= reqWstrbD;
      readData_M <= readDataD;
      fault      <= faultD;
    end
  end

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: table of single transactions plus
// hand-written back-pressure and mid-transaction reset sequences.
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [63:0] addr, storeData, readData_M;
  logic        stall, fault;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;

  int nVec  = 0;
  int nFail = 0;
  int hsCount = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] rdata;
    logic        expFault;
    logic [63:0] expAddr;
    logic [63:0] expWdata;
    logic [7:0]  expStrb;
    logic [63:0] expRead;
  } vecT;

  vecT vecs[16];

  data_mem_port #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .addr(addr), .storeData(storeData), .readData_M(readData_M),
    .stall(stall), .fault(fault),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && req_valid && req_ready) hsCount <= hsCount + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(input vecT v, input int idx);
    MemRead    = !v.wr;
    MemWrite   = v.wr;
    funct3     = v.f3;
    addr       = v.addr;
    storeData  = v.sdata;
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    #1;
    check($sformatf("v%0d stall_req", idx), 64'(stall), 64'(!v.expFault));
    tick();
    if (v.expFault) begin
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      check($sformatf("v%0d fault", idx), 64'(fault), 64'd1);
      check($sformatf("v%0d no_valid", idx), 64'(req_valid), 64'd0);
      check($sformatf("v%0d stall_f", idx), 64'(stall), 64'd0);
      check($sformatf("v%0d rdata_kept", idx), readData_M, v.expRead);
      tick();
      check($sformatf("v%0d fault_end", idx), 64'(fault), 64'd0);
    end else begin
      check($sformatf("v%0d valid", idx), 64'(req_valid), 64'd1);
      check($sformatf("v%0d write", idx), 64'(req_write), 64'(v.wr));
      check($sformatf("v%0d addr", idx), req_addr, v.expAddr);
      check($sformatf("v%0d wstrb", idx), 64'(req_wstrb), 64'(v.expStrb));
      if (v.wr) check($sformatf("v%0d wdata", idx), req_wdata, v.expWdata);
      check($sformatf("v%0d stall_req1", idx), 64'(stall), 64'd1);
      tick();
      check($sformatf("v%0d valid_drop", idx), 64'(req_valid), 64'd0);
      check($sformatf("v%0d stall_resp", idx), 64'(stall), 64'd1);
      resp_valid = 1'b1;
      resp_rdata = v.rdata;
      tick();
      resp_valid = 1'b0;
      check($sformatf("v%0d stall_done", idx), 64'(stall), 64'd0);
      check($sformatf("v%0d readData", idx), readData_M, v.expRead);
      MemRead = 1'b0; MemWrite = 1'b0;
      tick();
      check($sformatf("v%0d idle_novalid", idx), 64'(req_valid), 64'd0);
    end
  endtask

  initial begin
    int base;
    //          wr    f3      addr        sdata                  rdata                  flt   expAddr     expWdata               strb   expRead
    vecs[0]  = '{1'b0, 3'b000, 64'h1003, 64'h0,                 64'h0000_0000_80FF_0000, 1'b0, 64'h1000, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1'b0, 3'b110, 64'h2004, 64'h0,                 64'h8765_4321_0000_0000, 1'b0, 64'h2000, 64'h0,                 8'h00, 64'h0000_0000_8765_4321};
    vecs[2]  = '{1'b1, 3'b001, 64'h1006, 64'hBEEF,              64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h1000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0000_0000_8765_4321};
    vecs[3]  = '{1'b0, 3'b001, 64'h0012, 64'h0,                 64'h0000_0000_8001_0000, 1'b0, 64'h0010, 64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_8001};
    vecs[4]  = '{1'b0, 3'b101, 64'h0012, 64'h0,                 64'h0000_0000_8001_0000, 1'b0, 64'h0010, 64'h0,                 8'h00, 64'h0000_0000_0000_8001};
    vecs[5]  = '{1'b0, 3'b010, 64'h3002, 64'h0,                 64'h0,                   1'b1, 64'h0,    64'h0,                 8'h00, 64'h0000_0000_0000_8001};
    vecs[6]  = '{1'b0, 3'b011, 64'h4000, 64'h0,                 64'h0123_4567_89AB_CDEF, 1'b0, 64'h4000, 64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[7]  = '{1'b0, 3'b111, 64'h3000, 64'h0,                 64'h0,                   1'b1, 64'h0,    64'h0,                 8'h00, 64'h0123_4567_89AB_CDEF};
    vecs[8]  = '{1'b0, 3'b010, 64'h4004, 64'h0,                 64'h8000_0000_0000_0000, 1'b0, 64'h4000, 64'h0,                 8'h00, 64'hFFFF_FFFF_8000_0000};
    vecs[9]  = '{1'b0, 3'b100, 64'h4007, 64'h0,                 64'hA500_0000_0000_0000, 1'b0, 64'h4000, 64'h0,                 8'h00, 64'h0000_0000_0000_00A5};
    vecs[10] = '{1'b1, 3'b010, 64'h6004, 64'hFFFF_FFFF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h6000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0000_0000_0000_00A5};
    vecs[11] = '{1'b1, 3'b011, 64'h7000, 64'h1122_3344_5566_7788, 64'h0,                   1'b0, 64'h7000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0000_0000_0000_00A5};
    vecs[12] = '{1'b1, 3'b100, 64'h3000, 64'h55,                64'h0,                   1'b1, 64'h0,    64'h0,                 8'h00, 64'h0000_0000_0000_00A5};
    vecs[13] = '{1'b1, 3'b011, 64'h3004, 64'h55,                64'h0,                   1'b1, 64'h0,    64'h0,                 8'h00, 64'h0000_0000_0000_00A5};
    vecs[14] = '{1'b0, 3'b001, 64'h3001, 64'h0,                 64'h0,                   1'b1, 64'h0,    64'h0,                 8'h00, 64'h0000_0000_0000_00A5};
    vecs[15] = '{1'b1, 3'b000, 64'h5005, 64'hAB,                64'h0,                   1'b0, 64'h5000, 64'h0000_AB00_0000_0000, 8'h20, 64'h0000_0000_0000_00A5};

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    addr = '0; storeData = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
    #12;
    check("rst readData", readData_M, 64'h0);
    check("rst req_valid", 64'(req_valid), 64'd0);
    check("rst req_write", 64'(req_write), 64'd0);
    check("rst req_addr", req_addr, 64'h0);
    check("rst req_wdata", req_wdata, 64'h0);
    check("rst req_wstrb", 64'(req_wstrb), 64'd0);
    check("rst fault", 64'(fault), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) runVec(vecs[i], i);

    // Back-pressure: ready held low for four REQ cycles.
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b011; addr = 64'h8000; req_ready = 1'b0;
    base = hsCount;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d valid", i), 64'(req_valid), 64'd1);
      check($sformatf("bp%0d addr", i), req_addr, 64'h8000);
      check($sformatf("bp%0d write", i), 64'(req_write), 64'd0);
      check($sformatf("bp%0d stall", i), 64'(stall), 64'd1);
      tick();
    end
    req_ready = 1'b1;
    check("bp valid_at_ready", 64'(req_valid), 64'd1);
    tick();
    check("bp valid_drop", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_rdata = 64'hFEDC_BA98_7654_3210;
    tick();
    resp_valid = 1'b0;
    check("bp readData", readData_M, 64'hFEDC_BA98_7654_3210);
    MemRead = 1'b0;
    tick(); tick();
    check("bp one_transfer", 64'(hsCount - base), 64'd1);

    // Reset while waiting in RESP, then a late response arrives.
    MemRead = 1'b1; funct3 = 3'b100; addr = 64'h9001; req_ready = 1'b1;
    tick();
    tick();
    check("rr in_resp_stall", 64'(stall), 64'd1);
    MemRead = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rr readData", readData_M, 64'h0);
    check("rr stall", 64'(stall), 64'd0);
    check("rr valid", 64'(req_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_valid = 1'b1; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    resp_valid = 1'b0;
    check("rr late_readData", readData_M, 64'h0);
    check("rr late_stall", 64'(stall), 64'd0);
    check("rr late_valid", 64'(req_valid), 64'd0);

    // Reset while a request is pending drops req_valid at once.
    MemRead = 1'b1; funct3 = 3'b011; addr = 64'h9008; req_ready = 1'b0;
    tick();
    check("rq valid", 64'(req_valid), 64'd1);
    MemRead = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rq valid_drop", 64'(req_valid), 64'd0);
    check("rq addr_clear", req_addr, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("rq idle_valid", 64'(req_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
